// File: rtl/serial_subtractor_if.sv
// ---------------------------------------------------------------------------
// serial_subtractor_if : start/busy/done handshake and operand/result bus
//                        for the bit-serial subtractor.
// Optional: SERIAL_SUB_OVERFLOW_EN adds the signed-overflow flag ovf.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, bin,
`ifdef SERIAL_SUB_OVERFLOW_EN
    input  ovf,
`endif
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
`ifdef SERIAL_SUB_OVERFLOW_EN
    output ovf,
`endif
    output busy, done, diff, bout
  );
endinterface

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor : LSB-first ripple-borrow subtractor, A - B - Bin over
//                     WIDTH cycles with one full-subtractor cell.
// Optional: SERIAL_SUB_OVERFLOW_EN adds the signed-overflow output ovf.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  wire logic           clk,
  input  wire logic           rst,
  serial_subtractor_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_part;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             w_x;
  logic             w_y;
  logic             w_d;
  logic             w_br_nxt;
  logic             w_accept;
  logic             w_last;

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;
`endif

  // Single full-subtractor cell operating on the current LSBs
  assign w_x      = r_a[0];
  assign w_y      = r_b[0];
  assign w_d      = w_x ^ w_y ^ r_br;
  assign w_br_nxt = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);
  assign w_accept = (r_state == S_IDLE) && bus.start;
  assign w_last   = (r_state == S_RUN) && (r_cnt == c_last);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == c_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_part <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_a    <= bus.a;
      r_b    <= bus.b;
      r_part <= '0;
      r_br   <= bus.bin;
      r_cnt  <= '0;
    end else if (r_state == S_RUN) begin
      r_a    <= r_a >> 1;
      r_b    <= r_b >> 1;
      // Newest bit enters at the top; after WIDTH-1 steps bit 0 sits at the LSB
      r_part <= (WIDTH-1)'({w_d, r_part} >> 1);
      r_br   <= w_br_nxt;
      r_cnt  <= r_cnt + CW'(1);
    end
  end

  // Published result only changes on the edge that enters DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_diff <= '0;
      r_bout <= 1'b0;
    end else if (w_last) begin
      r_diff <= {w_d, r_part};
      r_bout <= w_br_nxt;
    end
  end

`ifdef SERIAL_SUB_OVERFLOW_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a_msb <= bus.a[WIDTH-1];
      r_b_msb <= bus.b[WIDTH-1];
    end else if (w_last) begin
      r_ovf   <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
    end
  end

  assign bus.ovf = r_ovf;
`endif

  assign bus.busy = (r_state == S_RUN);
  assign bus.done = (r_state == S_DONE);
  assign bus.diff = r_diff;
  assign bus.bout = r_bout;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor : self-checking bench for serial_subtractor (WIDTH=8
//                        and WIDTH=4 instances sharing clk/rst).
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_serial_subtractor;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  serial_subtractor_if #(.WIDTH(8)) i8 ();
  serial_subtractor_if #(.WIDTH(4)) i4 ();

  serial_subtractor #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(i8.slave));
  serial_subtractor #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(i4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Reference: plain unsigned/signed arithmetic
  function automatic logic [7:0] m_diff8(input int a, input int b, input int bin);
    return 8'((a - b - bin) & 32'hFF);
  endfunction

  function automatic logic m_bout(input int a, input int b, input int bin);
    return (a < b + bin);
  endfunction

  function automatic logic m_ovf8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    int sd;
    sd = int'($signed(a)) - int'($signed(b)) - int'(bin);
    return (sd > 127) || (sd < -128);
  endfunction

  // Launch an op on the 8-bit DUT and wait for done (bounded)
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                     output logic [7:0] d, output logic bo, output logic ov,
                     output int lat, output int busyc, output logic one_wide);
    @(negedge clk);
    i8.a = a; i8.b = b; i8.bin = bin; i8.start = 1'b1;
    @(posedge clk); #1;
    i8.start = 1'b0;
    lat = 0; busyc = 0;
    while (!i8.done && lat < 50) begin
      if (i8.busy) busyc++;
      @(posedge clk); #1;
      lat++;
    end
    d = i8.diff; bo = i8.bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
    ov = i8.ovf;
`else
    ov = 1'b0;
`endif
    @(posedge clk); #1;
    one_wide = !i8.done;
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                     output logic [3:0] d, output logic bo,
                     output int lat, output logic one_wide);
    @(negedge clk);
    i4.a = a; i4.b = b; i4.bin = bin; i4.start = 1'b1;
    @(posedge clk); #1;
    i4.start = 1'b0;
    lat = 0;
    while (!i4.done && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    d = i4.diff; bo = i4.bout;
    @(posedge clk); #1;
    one_wide = !i4.done;
  endtask

  initial begin
    logic [7:0] d8, ra, rb;
    logic [3:0] d4;
    logic       bo, ov, w1, rbin;
    int         lat, busyc, cnt;

    total = 0; bad = 0;
    i8.start = 0; i8.a = '0; i8.b = '0; i8.bin = 0;
    i4.start = 0; i4.a = '0; i4.b = '0; i4.bin = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_busy", 32'(i8.busy), 0);
    chk("rst_done", 32'(i8.done), 0);
    chk("rst_diff", 32'(i8.diff), 0);
    chk("rst_bout", 32'(i8.bout), 0);

    vt[0] = '{8'd100, 8'd37,  1'b0, 8'd63,  1'b0};
    vt[1] = '{8'd5,   8'd10,  1'b0, 8'd251, 1'b1};
    vt[2] = '{8'd0,   8'd0,   1'b1, 8'd255, 1'b1};
    vt[3] = '{8'd255, 8'd255, 1'b1, 8'd255, 1'b1};
    vt[4] = '{8'd0,   8'd255, 1'b0, 8'd1,   1'b1};
    vt[5] = '{8'd255, 8'd0,   1'b1, 8'd254, 1'b0};
    vt[6] = '{8'd128, 8'd128, 1'b0, 8'd0,   1'b0};

    for (int i = 0; i < 7; i++) begin
      op8(vt[i].a, vt[i].b, vt[i].bin, d8, bo, ov, lat, busyc, w1);
      chk($sformatf("vec%0d_diff", i), 32'(d8), 32'(vt[i].d));
      chk($sformatf("vec%0d_bout", i), 32'(bo), 32'(vt[i].bo));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 8);
      chk($sformatf("vec%0d_busy", i), 32'(busyc), 8);
      chk($sformatf("vec%0d_done1", i), 32'(w1), 1);
    end

`ifdef SERIAL_SUB_OVERFLOW_EN
    op8(8'h80, 8'h01, 1'b0, d8, bo, ov, lat, busyc, w1);
    chk("ovf1_diff", 32'(d8), 32'h7F);
    chk("ovf1_ovf", 32'(ov), 1);
    op8(8'h10, 8'h01, 1'b0, d8, bo, ov, lat, busyc, w1);
    chk("ovf0_diff", 32'(d8), 32'h0F);
    chk("ovf0_ovf", 32'(ov), 0);
`endif

    // Random operands against the arithmetic model
    for (int i = 0; i < 150; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rbin = 1'($urandom_range(0, 1));
      op8(ra, rb, rbin, d8, bo, ov, lat, busyc, w1);
      chk("rnd_diff", 32'(d8), 32'(m_diff8(int'(ra), int'(rb), int'(rbin))));
      chk("rnd_bout", 32'(bo), 32'(m_bout(int'(ra), int'(rb), int'(rbin))));
      chk("rnd_lat", 32'(lat), 8);
`ifdef SERIAL_SUB_OVERFLOW_EN
      chk("rnd_ovf", 32'(ov), 32'(m_ovf8(ra, rb, rbin)));
`endif
    end

    // Exhaustive 4-bit sweep
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++) begin
          op4(4'(a), 4'(b), 1'(c), d4, bo, lat, w1);
          chk("ex4_diff", 32'(d4), 32'((a - b - c) & 15));
          chk("ex4_bout", 32'(bo), 32'(m_bout(a, b, c)));
          chk("ex4_lat", 32'(lat), 4);
          chk("ex4_done1", 32'(w1), 1);
        end

    // Start held/re-asserted while busy, operands changed mid-RUN
    @(negedge clk);
    i8.a = 8'd200; i8.b = 8'd1; i8.bin = 1'b0; i8.start = 1'b1;
    @(posedge clk); #1;
    i8.a = 8'd9; i8.b = 8'd9;
    lat = 0;
    while (!i8.done && lat < 50) begin
      if (lat == 3) begin
        i8.a = 8'd77; i8.b = 8'd250; i8.bin = 1'b1;
      end
      if (lat == 5) i8.start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk("busy_start_diff", 32'(i8.diff), 199);
    chk("busy_start_bout", 32'(i8.bout), 0);
    chk("busy_start_lat", 32'(lat), 8);
    // Start offered only during the DONE cycle must be ignored
    i8.start = 1'b1;
    @(posedge clk); #1;
    i8.start = 1'b0;
    cnt = 0;
    repeat (3) begin
      if (i8.busy) cnt++;
      @(posedge clk); #1;
    end
    chk("done_start_ignored", 32'(cnt), 0);
    chk("done_hold_diff", 32'(i8.diff), 199);

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    i8.a = 8'd50; i8.b = 8'd20; i8.bin = 1'b0; i8.start = 1'b1;
    @(posedge clk); #1;
    i8.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(i8.busy), 0);
    chk("arst_done", 32'(i8.done), 0);
    chk("arst_diff", 32'(i8.diff), 0);
    chk("arst_bout", 32'(i8.bout), 0);
    cnt = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (i8.done) cnt++;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (i8.done) cnt++;
    end
    chk("arst_no_done", 32'(cnt), 0);
    op8(8'd50, 8'd20, 1'b0, d8, bo, ov, lat, busyc, w1);
    chk("post_rst_diff", 32'(d8), 30);
    chk("post_rst_bout", 32'(bo), 0);
    chk("post_rst_lat", 32'(lat), 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
